mux_packer: RTL and testbench

//  Downstream of the byte demux and the three decryption channels (caesar/scytale/zigzag).
//  - Selects one channel's byte stream and packs SYS_DWIDTH bytes into MST_DWIDTH words, first byte in the MSBs.
//  - Buffers completed words in a small FIFO and presents them to the master side with a valid/ready handshake.

---
 rtl/mux_packer_if.sv | 24 ++
 rtl/mux_packer.sv | 188 ++++++++++++++++++
 tb/tb_mux_packer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_packer_if.sv
// mux_packer_if: master-side word stream of mux_packer.
// data_o/valid_o/drop_o from packer, ready_i from consumer.
interface mux_packer_if #(
  parameter int DW = 32
) ();
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic          drop_o;

  modport master (
    output data_o,
    output valid_o,
    output drop_o,
    input  ready_i
  );

  modport slave (
    input  data_o,
    input  valid_o,
    input  drop_o,
    output ready_i
  );
endinterface

// File: rtl/mux_packer.sv
// mux_packer: picks one decrypt channel, packs bytes MSB-first into words,
// buffers words in a FWFT FIFO behind a valid/ready handshake.
// Ports: clk_sys, rst (sync, active-high), select (3 = none),
//   data0_i/valid0_i .. data2_i/valid2_i channel bytes,
//   m_if.master: data_o, valid_o, ready_i, drop_o (sticky overflow).
// Option: MUX_PACKER_FLUSH_EN flushes a partial word after
//   FLUSH_CYCLES idle cycles, zero-padded in the LSBs.
module mux_packer #(
  parameter int MST_DWIDTH   = 32,
  parameter int SYS_DWIDTH   = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic                  clk_sys,
  input  logic                  rst,
  input  logic [1:0]            select,
  input  logic [SYS_DWIDTH-1:0] data0_i,
  input  logic                  valid0_i,
  input  logic [SYS_DWIDTH-1:0] data1_i,
  input  logic                  valid1_i,
  input  logic [SYS_DWIDTH-1:0] data2_i,
  input  logic                  valid2_i,
  mux_packer_if.master          m_if
);

  localparam int N  = MST_DWIDTH / SYS_DWIDTH;
  localparam int CW = $clog2(N) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [1:0]            r_prev_sel;
  logic [CW-1:0]         r_cnt;
  logic [MST_DWIDTH-1:0] r_sr;

  logic                  w_acc;
  logic                  w_sel_chg;
  logic                  w_last;
  logic                  w_flush;
  logic                  w_push_req;
  logic [SYS_DWIDTH-1:0] w_byte;
  logic [CW-1:0]         w_cnt_base;
  logic [MST_DWIDTH-1:0] w_sr_base;
  logic [MST_DWIDTH-1:0] w_word;
  logic [MST_DWIDTH-1:0] w_push_data;

  always_comb begin
    w_byte = '0;
    w_acc  = 1'b0;
    case (select)
      2'd0: begin
        w_byte = data0_i;
        w_acc  = valid0_i;
      end
      2'd1: begin
        w_byte = data1_i;
        w_acc  = valid1_i;
      end
      2'd2: begin
        w_byte = data2_i;
        w_acc  = valid2_i;
      end
      default: ;
    endcase
  end

  // A select change drops the partial word; a byte in the
  // same cycle starts the new word at position 0.
  assign w_sel_chg  = (select != r_prev_sel);
  assign w_cnt_base = w_sel_chg ? '0 : r_cnt;
  assign w_sr_base  = w_sel_chg ? '0 : r_sr;
  assign w_last     = (w_cnt_base == CW'(N - 1));

  always_comb begin
    w_word = w_sr_base;
    for (int k = 0; k < N; k++) begin
      if (w_cnt_base == CW'(k))
        w_word[(N-1-k)*SYS_DWIDTH +: SYS_DWIDTH] = w_byte;
    end
  end

`ifdef MUX_PACKER_FLUSH_EN
  localparam int IW = $clog2(FLUSH_CYCLES + 1);

  logic [IW-1:0] r_idle;

  assign w_flush = !w_acc && (w_cnt_base != '0) &&
                   (r_idle + 1'b1 == IW'(FLUSH_CYCLES));

  always_ff @(posedge clk_sys) begin
    if (rst || w_acc || (w_cnt_base == '0) || w_flush)
      r_idle <= '0;
    else
      r_idle <= r_idle + 1'b1;
  end
`else
  // Partial words wait for completion; flush never fires.
  assign w_flush = (FLUSH_CYCLES < 0);
`endif

  // Unfilled byte lanes of r_sr are always zero, so a flushed
  // word is already zero-padded.
  assign w_push_req  = (w_acc && w_last) || w_flush;
  assign w_push_data = w_flush ? w_sr_base : w_word;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_prev_sel <= 2'd0;
      r_cnt      <= '0;
      r_sr       <= '0;
    end else begin
      r_prev_sel <= select;
      if (w_acc) begin
        r_cnt <= w_last ? '0 : w_cnt_base + 1'b1;
        r_sr  <= w_last ? '0 : w_word;
      end else if (w_flush) begin
        r_cnt <= '0;
        r_sr  <= '0;
      end else begin
        r_cnt <= w_cnt_base;
        r_sr  <= w_sr_base;
      end
    end
  end

  logic [MST_DWIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wp;
  logic [AW-1:0]         r_rp;
  logic [AW:0]           r_fcnt;
  logic [MST_DWIDTH-1:0] r_data;
  logic                  r_drop;

  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic [AW-1:0]         w_rp_nxt;
  logic [MST_DWIDTH-1:0] w_head;

  assign w_full   = (r_fcnt == (AW+1)'(FIFO_DEPTH));
  assign w_pop    = (r_fcnt != '0) && m_if.ready_i;
  assign w_push   = w_push_req && (!w_full || w_pop);
  assign w_rp_nxt = r_rp + 1'b1;

  // Registered head: next head word, or hold when the FIFO
  // goes empty so data_o keeps its last value.
  always_comb begin
    w_head = r_data;
    if (w_pop) begin
      if (r_fcnt > (AW+1)'(1))
        w_head = r_mem[w_rp_nxt];
      else if (w_push)
        w_head = w_push_data;
    end else if ((r_fcnt == '0) && w_push) begin
      w_head = w_push_data;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (w_push)
      r_mem[r_wp] <= w_push_data;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_fcnt <= '0;
      r_data <= '0;
      r_drop <= 1'b0;
    end else begin
      if (w_push)
        r_wp <= r_wp + 1'b1;
      if (w_pop)
        r_rp <= w_rp_nxt;
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + 1'b1;
        2'b01:   r_fcnt <= r_fcnt - 1'b1;
        default: r_fcnt <= r_fcnt;
      endcase
      r_data <= w_head;
      if (w_push_req && w_full && !w_pop)
        r_drop <= 1'b1;
    end
  end

  assign m_if.data_o  = r_data;
  assign m_if.valid_o = (r_fcnt != '0);
  assign m_if.drop_o  = r_drop;

endmodule

// File: tb/tb_mux_packer.sv
// tb_mux_packer: cycle vectors for packing/select/reset,
// plus sequences for FIFO full, drop, and partial-word flush.
module tb_mux_packer;

  logic       clk_sys = 1'b0;
  logic       rst;
  logic [1:0] select;
  logic [7:0] data0_i, data1_i, data2_i;
  logic       valid0_i, valid1_i, valid2_i;

  int checks = 0;
  int errors = 0;

  mux_packer_if #(.DW(32)) m_if ();

  mux_packer #(
    .MST_DWIDTH(32),
    .SYS_DWIDTH(8),
    .FIFO_DEPTH(4),
    .FLUSH_CYCLES(16)
  ) dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .select  (select),
    .data0_i (data0_i),
    .valid0_i(valid0_i),
    .data1_i (data1_i),
    .valid1_i(valid1_i),
    .data2_i (data2_i),
    .valid2_i(valid2_i),
    .m_if    (m_if)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic        rst;
    logic [1:0]  sel;
    logic [7:0]  d0;
    logic        v0;
    logic [7:0]  d1;
    logic        v1;
    logic [7:0]  d2;
    logic        v2;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic        edrop;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [1:0] s,
                     input logic [7:0] d0, input logic v0,
                     input logic [7:0] d1, input logic v1,
                     input logic [7:0] d2, input logic v2,
                     input logic rdy, input logic ev,
                     input logic [31:0] ed, input logic edrop);
    vec_t v;
    v.rst = r; v.sel = s;
    v.d0 = d0; v.v0 = v0;
    v.d1 = d1; v.v1 = v1;
    v.d2 = d2; v.v2 = v2;
    v.rdy = rdy; v.ev = ev;
    v.ed = ed; v.edrop = edrop;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic ev,
                     input logic [31:0] ed, input logic edrop);
    checks += 3;
    if (m_if.valid_o !== ev) begin
      errors++;
      $display("FAIL %s valid_o got %0b exp %0b", nm, m_if.valid_o, ev);
    end
    if (m_if.data_o !== ed) begin
      errors++;
      $display("FAIL %s data_o got %08h exp %08h", nm, m_if.data_o, ed);
    end
    if (m_if.drop_o !== edrop) begin
      errors++;
      $display("FAIL %s drop_o got %0b exp %0b", nm, m_if.drop_o, edrop);
    end
  endtask

  task automatic idle_in();
    valid0_i = 0; valid1_i = 0; valid2_i = 0;
    data0_i = 0; data1_i = 0; data2_i = 0;
  endtask

  task automatic drv(input logic [1:0] s, input int ch,
                     input logic [7:0] b, input logic rdy);
    idle_in();
    select = s;
    m_if.ready_i = rdy;
    case (ch)
      0: begin data0_i = b; valid0_i = 1; end
      1: begin data1_i = b; valid1_i = 1; end
      2: begin data2_i = b; valid2_i = 1; end
      default: ;
    endcase
    @(posedge clk_sys); #1;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1;
    @(posedge clk_sys); #1;
    rst = 0;
  endtask

  task automatic push_word(input logic [1:0] s,
                           input logic [31:0] w,
                           input logic rdy_last);
    drv(s, s, w[31:24], 0);
    drv(s, s, w[23:16], 0);
    drv(s, s, w[15:8], 0);
    drv(s, s, w[7:0], rdy_last);
  endtask

  initial begin
    rst = 1; select = 0; m_if.ready_i = 0;
    idle_in();

    // reset
    add(1,0, 8'h00,0, 8'h00,0, 8'h00,0, 0, 0,32'h0,0);
    // ch1 word, 1-cycle latency, then pop
    add(0,1, 8'h00,0, 8'h11,1, 8'h00,0, 1, 0,32'h0,0);
    add(0,1, 8'h00,0, 8'h22,1, 8'h00,0, 1, 0,32'h0,0);
    add(0,1, 8'h00,0, 8'h33,1, 8'h00,0, 1, 0,32'h0,0);
    add(0,1, 8'h00,0, 8'h44,1, 8'h00,0, 1, 1,32'h11223344,0);
    add(0,1, 8'h00,0, 8'h00,0, 8'h00,0, 1, 0,32'h11223344,0);
    // ch0 selected, ch2 active simultaneously is ignored
    add(0,0, 8'hA1,1, 8'h00,0, 8'hF1,1, 1, 0,32'h11223344,0);
    add(0,0, 8'hA2,1, 8'h00,0, 8'hF2,1, 1, 0,32'h11223344,0);
    add(0,0, 8'hA3,1, 8'h00,0, 8'hF3,1, 1, 0,32'h11223344,0);
    add(0,0, 8'hA4,1, 8'h00,0, 8'hF4,1, 1, 1,32'hA1A2A3A4,0);
    add(0,0, 8'h00,0, 8'h00,0, 8'h00,0, 1, 0,32'hA1A2A3A4,0);
    // partial on ch2 discarded by select change to ch0
    add(0,2, 8'h00,0, 8'h00,0, 8'h01,1, 1, 0,32'hA1A2A3A4,0);
    add(0,2, 8'h00,0, 8'h00,0, 8'h02,1, 1, 0,32'hA1A2A3A4,0);
    add(0,0, 8'h0A,1, 8'h00,0, 8'h03,1, 1, 0,32'hA1A2A3A4,0);
    add(0,0, 8'h0B,1, 8'h00,0, 8'h00,0, 1, 0,32'hA1A2A3A4,0);
    add(0,0, 8'h0C,1, 8'h00,0, 8'h00,0, 1, 0,32'hA1A2A3A4,0);
    add(0,0, 8'h0D,1, 8'h00,0, 8'h00,0, 1, 1,32'h0A0B0C0D,0);
    add(0,0, 8'h00,0, 8'h00,0, 8'h00,0, 1, 0,32'h0A0B0C0D,0);
    // reset mid-word clears partial and data_o
    add(0,0, 8'h55,1, 8'h00,0, 8'h00,0, 1, 0,32'h0A0B0C0D,0);
    add(0,0, 8'h66,1, 8'h00,0, 8'h00,0, 1, 0,32'h0A0B0C0D,0);
    add(1,0, 8'h77,1, 8'h00,0, 8'h00,0, 1, 0,32'h0,0);
    add(0,0, 8'h88,1, 8'h00,0, 8'h00,0, 1, 0,32'h0,0);
    add(0,0, 8'h99,1, 8'h00,0, 8'h00,0, 1, 0,32'h0,0);
    add(0,0, 8'hAA,1, 8'h00,0, 8'h00,0, 1, 0,32'h0,0);
    add(0,0, 8'hBB,1, 8'h00,0, 8'h00,0, 1, 1,32'h8899AABB,0);
    add(0,0, 8'h00,0, 8'h00,0, 8'h00,0, 1, 0,32'h8899AABB,0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      select = vecs[i].sel;
      data0_i = vecs[i].d0; valid0_i = vecs[i].v0;
      data1_i = vecs[i].d1; valid1_i = vecs[i].v1;
      data2_i = vecs[i].d2; valid2_i = vecs[i].v2;
      m_if.ready_i = vecs[i].rdy;
      @(posedge clk_sys); #1;
      chk($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].edrop);
    end
    rst = 0;

    // overflow: 5 words with no consumer
    for (int i = 0; i < 5; i++)
      push_word(2'd1, 32'hA0A0A0A0 + i, 0);
    idle_in();
    chk("ovf_full", 1, 32'hA0A0A0A0, 1);
    m_if.ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_pop%0d", i), 1, 32'hA0A0A0A0 + i, 1);
      @(posedge clk_sys); #1;
    end
    chk("ovf_empty", 0, 32'hA0A0A0A3, 1);
    do_reset();
    chk("ovf_reset", 0, 32'h0, 0);

    // full FIFO, push and pop in the same cycle
    for (int i = 0; i < 4; i++)
      push_word(2'd1, 32'hB0B0B0B0 + i, 0);
    idle_in();
    chk("pp_full", 1, 32'hB0B0B0B0, 0);
    push_word(2'd1, 32'hB0B0B0B4, 1);
    chk("pp_same", 1, 32'hB0B0B0B1, 0);
    idle_in();
    m_if.ready_i = 1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("pp_pop%0d", i), 1, 32'hB0B0B0B0 + i, 0);
      @(posedge clk_sys); #1;
    end
    chk("pp_empty", 0, 32'hB0B0B0B4, 0);

    // partial word then idle
    do_reset();
    chk("fl_reset", 0, 32'h0, 0);
    drv(2'd0, 0, 8'hDE, 1);
    drv(2'd0, 0, 8'hAD, 1);
    idle_in();
    for (int i = 0; i < 15; i++) begin
      @(posedge clk_sys); #1;
    end
    chk("fl_idle15", 0, 32'h0, 0);
    @(posedge clk_sys); #1;
`ifdef MUX_PACKER_FLUSH_EN
    chk("fl_flush", 1, 32'hDEAD0000, 0);
    @(posedge clk_sys); #1;
    chk("fl_popped", 0, 32'hDEAD0000, 0);
`else
    chk("fl_hold", 0, 32'h0, 0);
    drv(2'd0, 0, 8'hBE, 1);
    drv(2'd0, 0, 8'hEF, 1);
    idle_in();
    chk("fl_done", 1, 32'hDEADBEEF, 0);
    @(posedge clk_sys); #1;
    chk("fl_popped", 0, 32'hDEADBEEF, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
